mailbox_slave: RTL and testbench

MAILBOX_SLAVE -- requirements
Module: mailbox_slave

---
 rtl/mailbox_slave.sv | 241 ++++++++++++++++++++++++
 tb/tb_mailbox_slave.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mailbox_slave.sv
// -----------------------------------------------------------------------------
// mailbox_slave
//
// Bus slave that gives a local consumer a small byte FIFO. The bus master
// pushes bytes through register offset 0, and the local side drains them with
// a valid/ready pop port.
//
// Register map (addr[1:0]):
//   0  W: push wdata          R: FIFO head, no pop (8'h00 if empty, sets unf)
//   1  W: ignored             R: {ovf, unf, full, empty, count[3:0]}
//   2  W: wdata[0]=1 flushes the FIFO and clears ovf/unf    R: 8'h00
//   3  W: ignored             R: 8'h00
//
// Ports:
//   clk, rst_n     single rising-edge clock, asynchronous active-low reset
//   addr, wdata    bus address (only [1:0] decoded) and write data
//   mode           1 = write, 0 = read
//   valid, sl      master request and decoder select
//   rdata, ready   read data and one-cycle transfer-complete strobe
//   lo_data        FIFO head (combinational)
//   lo_valid       FIFO non-empty
//   lo_ready       local consumer pop request
//   dbg_state      current bus FSM state
//
// Bus handshake: the master raises valid (with sl) and holds it, together with
// addr/mode/wdata, until it sees ready. The slave samples the request in IDLE,
// commits on the next edge if valid is still high (dropping valid there
// cancels the transfer with no side effect), pulses ready for exactly one
// cycle two edges after the request was sampled, then waits for valid to
// fall before it will look at a new request.
//
// Local handshake: a pop happens on every rising edge where
// lo_valid & lo_ready.
// -----------------------------------------------------------------------------
module mailbox_slave #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   input  logic        mode,
   input  logic        valid,
   input  logic        sl,
   output logic [7:0]  rdata,
   output logic        ready,
   output logic [7:0]  lo_data,
   output logic        lo_valid,
   input  logic        lo_ready,
   output logic [1:0]  dbg_state
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic        accept;
   logic        commit;

   logic [1:0]  off_q;
   logic        mode_q;
   logic [7:0]  wdata_q;

   logic [7:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [4:0]  count;
   logic        ovf;
   logic        unf;
   logic        full;
   logic        empty;
   logic [7:0]  status;

   logic        push_req;
   logic        push_ok;
   logic        push_drop;
   logic        pop;
   logic        flush;
   logic        head_read;
   logic [7:0]  rdata_d;
   logic [7:0]  rdata_q;
   logic        ready_q;

   // Upper address bits belong to the system decoder, not to this block.
   logic        unused_addr;
   assign unused_addr = ^addr[15:2];

   // ---------------------------------------------------------------- bus FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (sl && valid) begin
               accept  = 1'b1;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (!valid) begin
               state_d = IDLE;
            end else begin
               commit  = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = DONE;
         end
         DONE: begin
            if (!valid) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign dbg_state = state_q;

   // Request fields are captured when the request is accepted so the commit
   // does not depend on the master keeping them stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         off_q   <= 2'd0;
         mode_q  <= 1'b0;
         wdata_q <= 8'h00;
      end else if (accept) begin
         off_q   <= addr[1:0];
         mode_q  <= mode;
         wdata_q <= wdata;
      end
   end

   // ---------------------------------------------------------------- FIFO
   assign full      = (count == 5'(DEPTH));
   assign empty     = (count == 5'd0);
   assign lo_valid  = !empty;
   assign lo_data   = mem[rd_ptr];
   assign status    = {ovf, unf, full, empty, count[3:0]};

   assign pop       = lo_valid && lo_ready;
   assign push_req  = commit && mode_q && (off_q == 2'd0);
   // A pop on the same edge frees the slot, so a push into a full FIFO is
   // still accepted then.
   assign push_ok   = push_req && (!full || pop);
   assign push_drop = push_req && full && !pop;
   assign flush     = commit && mode_q && (off_q == 2'd2) && wdata_q[0];
   assign head_read = commit && !mode_q && (off_q == 2'd0);

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= 5'd0;
         ovf    <= 1'b0;
         unf    <= 1'b0;
      end else if (flush) begin
         // Flush overrides a concurrent local pop.
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= 5'd0;
         ovf    <= 1'b0;
         unf    <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push_ok, pop})
            2'b10:   count <= count + 5'd1;
            2'b01:   count <= count - 5'd1;
            default: count <= count;
         endcase
         if (push_drop) begin
            ovf <= 1'b1;
         end
         if (head_read && empty) begin
            unf <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- read path
   // Read data reflects the state seen at the commit edge, before this
   // edge's push/pop/flush take effect. Writes load 8'h00.
   always_comb begin
      rdata_d = 8'h00;
      if (!mode_q) begin
         case (off_q)
            2'd0:    rdata_d = empty ? 8'h00 : mem[rd_ptr];
            2'd1:    rdata_d = status;
            default: rdata_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= 8'h00;
         ready_q <= 1'b0;
      end else begin
         if (commit) begin
            rdata_q <= rdata_d;
         end
         // Registered from RESP so the strobe lands in the cycle after the
         // RESP edge and lasts one cycle.
         ready_q <= (state_q == RESP);
      end
   end

   assign rdata = rdata_q;
   assign ready = ready_q;

endmodule

// File: tb/tb_mailbox_slave.sv
module tb_mailbox_slave;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        mode;
   logic        valid;
   logic        sl;
   logic [7:0]  rdata;
   logic        ready;
   logic [7:0]  lo_data;
   logic        lo_valid;
   logic        lo_ready;
   logic [1:0]  dbg_state;

   mailbox_slave #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .addr      (addr),
      .wdata     (wdata),
      .mode      (mode),
      .valid     (valid),
      .sl        (sl),
      .rdata     (rdata),
      .ready     (ready),
      .lo_data   (lo_data),
      .lo_valid  (lo_valid),
      .lo_ready  (lo_ready),
      .dbg_state (dbg_state)
   );

   // ---------------------------------------------------------- clock / reset
   always #5 clk = ~clk;

   // ---------------------------------------------------------- scoreboard
   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];   // FIFO contents as the spec describes them
   bit         m_ovf;
   bit         m_unf;
   int         lo_mode;    // 0: never pop, 1: random pops, 2: always pop

   // pending bus operation and its expected read data
   bit         p_mode;
   logic [1:0] p_off;
   logic [7:0] p_wdata;
   logic [7:0] exp_rd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] model_status();
      int n;
      n = exp_q.size();
      return {m_ovf, m_unf, (n == DEPTH), (n == 0), 4'(n)};
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // One clock: apply the spec rules for this edge to the model, then check.
   task automatic cycle(input bit do_commit, input bit exp_ready);
      bit pop;
      int pre;
      @(posedge clk);
      pre = exp_q.size();
      pop = lo_ready && (pre != 0);
      if (do_commit) begin
         exp_rd = 8'h00;
         if (!p_mode && p_off == 2'd0) begin
            if (pre == 0) exp_rd = 8'h00;
            else          exp_rd = exp_q[0];
         end
         if (!p_mode && p_off == 2'd1) exp_rd = model_status();
         if (!p_mode && p_off == 2'd0 && pre == 0) m_unf = 1'b1;
      end
      if (pop) void'(exp_q.pop_front());
      if (do_commit && p_mode) begin
         if (p_off == 2'd0) begin
            if (pre < DEPTH || pop) exp_q.push_back(p_wdata);
            else                    m_ovf = 1'b1;
         end
         if (p_off == 2'd2 && p_wdata[0]) model_reset();
      end
      #1;
      check("ready", ready, exp_ready);
      check("lo_valid", lo_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("lo_data", lo_data, exp_q[0]);
      if (exp_ready) check("rdata", rdata, exp_rd);
      case (lo_mode)
         0:       lo_ready = 1'b0;
         1:       lo_ready = 1'($urandom_range(0, 1));
         default: lo_ready = 1'b1;
      endcase
   endtask

   // ---------------------------------------------------------- driver tasks
   task automatic drive_req(input logic [1:0] off, input bit wr, input logic [7:0] wd);
      addr    = {14'($urandom_range(0, 16383)), off};
      mode    = wr;
      wdata   = wd;
      sl      = 1'b1;
      valid   = 1'b1;
      p_mode  = wr;
      p_off   = off;
      p_wdata = wd;
   endtask

   task automatic xfer(input logic [1:0] off, input bit wr, input logic [7:0] wd,
                       input bit drop, input bit hold, input bit pop_c);
      drive_req(off, wr, wd);
      cycle(1'b0, 1'b0);                  // request sampled in IDLE
      wdata = 8'($urandom);               // captured copy must be used
      if (pop_c) lo_ready = 1'b1;
      if (drop) begin
         valid = 1'b0;
         sl    = 1'b0;
         repeat (3) cycle(1'b0, 1'b0);
         return;
      end
      cycle(1'b1, 1'b0);                  // commit edge
      cycle(1'b0, 1'b1);                  // ready strobe
      if (hold) repeat (3) cycle(1'b0, 1'b0);
      valid = 1'b0;
      sl    = 1'b0;
      cycle(1'b0, 1'b0);
   endtask

   task automatic expect_status(input string tag, input logic [7:0] v);
      xfer(2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check(tag, rdata, v);
   endtask

   task automatic flush_fifo();
      xfer(2'd2, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
   endtask

   // ---------------------------------------------------------- stimulus
   initial begin
      rst_n    = 1'b0;
      addr     = 16'h0000;
      wdata    = 8'h00;
      mode     = 1'b0;
      valid    = 1'b0;
      sl       = 1'b0;
      lo_ready = 1'b0;
      lo_mode  = 0;
      model_reset();
      p_mode   = 1'b0;
      p_off    = 2'd0;
      p_wdata  = 8'h00;
      exp_rd   = 8'h00;

      #12;
      check("rst_ready", ready, 1'b0);
      check("rst_rdata", rdata, 8'h00);
      check("rst_lo_valid", lo_valid, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) cycle(1'b0, 1'b0);

      // valid without select must not start a transfer
      drive_req(2'd0, 1'b1, 8'h77);
      sl = 1'b0;
      repeat (3) cycle(1'b0, 1'b0);
      valid = 1'b0;
      cycle(1'b0, 1'b0);

      // single write, then status
      xfer(2'd0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      check("wr_lo_data", lo_data, 8'hA5);
      check("wr_lo_valid", lo_valid, 1'b1);
      expect_status("status_one", 8'h01);
      xfer(2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("peek_head", rdata, 8'hA5);
      expect_status("status_peek", 8'h01);

      // overflow: nine writes into an eight-entry FIFO
      flush_fifo();
      for (int i = 0; i < 9; i++) xfer(2'd0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      expect_status("status_ovf", 8'hA8);
      lo_mode = 2;
      repeat (10) cycle(1'b0, 1'b0);      // drain; the model holds only eight
      lo_mode = 0;
      expect_status("status_drained", 8'h90);

      // full FIFO, push with a pop on the same edge
      flush_fifo();
      for (int i = 0; i < 8; i++) xfer(2'd0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
      xfer(2'd0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
      expect_status("status_full_pop", 8'h28);
      lo_mode = 2;
      repeat (10) cycle(1'b0, 1'b0);
      lo_mode = 0;

      // read head when empty
      flush_fifo();
      xfer(2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("empty_read", rdata, 8'h00);
      expect_status("status_unf", 8'h50);

      // cancelled transfer, then flush clears flags
      xfer(2'd0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
      expect_status("status_cancel", 8'h50);
      flush_fifo();
      expect_status("status_flush", 8'h10);

      // offsets 2 and 3 read zero; writes to 1 and 3 are ignored
      xfer(2'd0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      xfer(2'd3, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
      xfer(2'd1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
      xfer(2'd3, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("off3_read", rdata, 8'h00);
      xfer(2'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("off2_read", rdata, 8'h00);
      expect_status("status_ignored", 8'h01);

      // reset while ready is high
      xfer(2'd0, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
      xfer(2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      drive_req(2'd0, 1'b1, 8'h99);
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("async_ready", ready, 1'b0);
      check("async_rdata", rdata, 8'h00);
      check("async_lo_valid", lo_valid, 1'b0);
      model_reset();
      valid    = 1'b0;
      sl       = 1'b0;
      lo_ready = 1'b0;
      #2 rst_n = 1'b1;
      repeat (3) cycle(1'b0, 1'b0);
      expect_status("status_after_rst", 8'h10);
      expect_status("status_after_rst2", 8'h10);

      // randomized traffic checked against the model
      for (int t = 0; t < 400; t++) begin
         logic [1:0] off;
         bit         wr;
         logic [7:0] wd;
         if (t % 50 == 0) lo_mode = int'($urandom_range(0, 2));
         off = 2'($urandom_range(0, 3));
         wr  = ($urandom_range(0, 2) != 0);
         wd  = 8'($urandom);
         if (off == 2'd2 && wr) wd[0] = ($urandom_range(0, 7) == 0);
         repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0);
         xfer(off, wr, wd, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 3) == 0));
         if (t % 40 == 39) expect_status("status_rand", model_status());
      end

      // final drain and status
      lo_mode = 2;
      repeat (DEPTH + 2) cycle(1'b0, 1'b0);
      lo_mode = 0;
      xfer(2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("final_empty", rdata[4], 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
